// File: rtl/readback_pkg.sv
// Shared state encoding and status-word layout for the sample readback path.
package readback_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2,
        READOUT = 2'd3
    } state_t;

    localparam int DEFAULT_DEPTH   = 1024;
    localparam int WORDS_W         = 12;

    localparam int ST_STATE_LSB    = 0;
    localparam int ST_UNDERRUN_BIT = 2;
    localparam int ST_DONE_BIT     = 3;
    localparam int ST_WORDS_LSB    = 4;

endpackage

// File: rtl/sample_ram.sv
// Capture store: one write port, one registered read port, storage not reset.
module sample_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sample_readback_pipe.sv
// Captures a block of samples into RAM, then streams them to a pipe-out
// endpoint with first-word-fall-through semantics.
module sample_readback_pipe
    import readback_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic [15:0]       length,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              ep_read,
    output logic [DATA_W-1:0] ep_datain,
    output logic [15:0]       status,
    output logic              done
);

    localparam int LEN_W = ADDR_W + 1;

    state_t             state, state_nx;
    logic [LEN_W-1:0]   wr_ptr, rd_ptr, eff_len, cap_len, arm_len;
    logic               pref_valid, underrun;
    logic [WORDS_W-1:0] words_read;
    logic               wr_en, last_wr, consume, last_rd;
    logic [ADDR_W-1:0]  raddr;
    logic [DATA_W-1:0]  rdata;

    always_comb begin
        arm_len = LEN_W'(length);
        if (length == 16'd0 || 32'(length) > DEPTH) arm_len = LEN_W'(DEPTH);
    end

    assign wr_en   = (state == CAPTURE) && sample_valid && !arm;
    assign last_wr = wr_en && (wr_ptr == eff_len - LEN_W'(1));
    assign consume = ep_read && pref_valid && !arm;
    assign last_rd = consume && (rd_ptr == cap_len - LEN_W'(1));

    // Look one word ahead on a consume so the next word lands with no bubble.
    assign raddr = consume ? rd_ptr[ADDR_W-1:0] + ADDR_W'(1) : rd_ptr[ADDR_W-1:0];

    sample_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (sample_in),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (arm) begin
            state_nx = CAPTURE;
        end else begin
            case (state)
                CAPTURE: if (last_wr) state_nx = READY;
                READY:   if (consume) state_nx = last_rd ? IDLE : READOUT;
                READOUT: if (last_rd) state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            eff_len    <= '0;
            cap_len    <= '0;
            pref_valid <= 1'b0;
            underrun   <= 1'b0;
            words_read <= '0;
        end else if (arm) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            eff_len    <= arm_len;
            cap_len    <= '0;
            pref_valid <= 1'b0;
            underrun   <= 1'b0;
            words_read <= '0;
        end else begin
            if (wr_en)   wr_ptr  <= wr_ptr + LEN_W'(1);
            if (last_wr) cap_len <= eff_len;
            if (consume) begin
                rd_ptr <= rd_ptr + LEN_W'(1);
                if (words_read != {WORDS_W{1'b1}}) words_read <= words_read + WORDS_W'(1);
            end
            if (ep_read && !pref_valid) underrun <= 1'b1;
            // Word 0 was addressed on the first READY cycle, so RAM output is valid from the next.
            if (last_rd)               pref_valid <= 1'b0;
            else if (state == READY)   pref_valid <= 1'b1;
        end
    end

    assign ep_datain = pref_valid ? rdata : '0;
    assign done      = pref_valid;

    always_comb begin
        status = '0;
        status[ST_STATE_LSB +: 2]       = state;
        status[ST_UNDERRUN_BIT]         = underrun;
        status[ST_DONE_BIT]             = pref_valid;
        status[ST_WORDS_LSB +: WORDS_W] = words_read;
    end

endmodule

// File: tb/tb_sample_readback_pipe.sv
// Bench: queue-based capture/readback model checked every cycle, plus directed pins.
module tb_sample_readback_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        arm;
    logic [15:0] length;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        ep_read;
    logic [15:0] ep_datain;
    logic [15:0] status;
    logic        done;

    int checks = 0;
    int errors = 0;

    sample_readback_pipe dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .arm          (arm),
        .length       (length),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .ep_read      (ep_read),
        .ep_datain    (ep_datain),
        .status       (status),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Model: captured samples in a queue, a read index, and how long READY has lasted.
    int          m_state  = 0;
    int          m_target = 0;
    int          m_rd     = 0;
    int          m_rdy    = 0;
    int          m_words  = 0;
    bit          m_under  = 1'b0;
    logic [15:0] m_q[$];
    logic [15:0] got_q[$];

    function automatic int clamp_len(input int l);
        return (l == 0 || l > 1024) ? 1024 : l;
    endfunction

    function automatic bit model_valid();
        return (m_state == 3) || (m_state == 2 && m_rdy >= 1);
    endfunction

    function automatic logic [15:0] model_data();
        return model_valid() ? m_q[m_rd] : 16'h0000;
    endfunction

    function automatic logic [15:0] model_status();
        return {12'(m_words), model_valid(), m_under, 2'(m_state)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin : model
        int old;
        bit avail;
        if (!reset_n) begin
            m_state = 0; m_target = 0; m_rd = 0; m_rdy = 0; m_words = 0; m_under = 1'b0;
            m_q.delete();
        end else if (arm) begin
            m_target = clamp_len(int'(length));
            m_q.delete();
            m_rd = 0; m_rdy = 0; m_words = 0; m_under = 1'b0;
            m_state = 1;
        end else begin
            old   = m_state;
            avail = model_valid();
            if (ep_read) begin
                if (avail) begin
                    m_rd++;
                    if (m_words < 4095) m_words++;
                    m_state = (m_rd == m_q.size()) ? 0 : 3;
                end else begin
                    m_under = 1'b1;
                end
            end
            if (old == 1 && sample_valid) begin
                m_q.push_back(sample_in);
                if (m_q.size() == m_target) begin
                    m_state = 2;
                    m_rdy   = 0;
                end
            end
            if (old == 2) m_rdy++;
        end
    end

    always @(negedge clk) begin
        chk("ep_datain", {16'h0, ep_datain}, {16'h0, model_data()});
        chk("done", {31'h0, done}, {31'h0, model_valid()});
        chk("status", {16'h0, status}, {16'h0, model_status()});
        if (ep_read && !arm && model_valid()) got_q.push_back(ep_datain);
    end

    task automatic cyc(input logic a, input logic [15:0] len, input logic sv,
                       input logic [15:0] s, input logic rd);
        arm = a; length = len; sample_valid = sv; sample_in = s; ep_read = rd;
        @(posedge clk); #2;
        arm = 1'b0; sample_valid = 1'b0; ep_read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, length, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] basic [4];
        logic [15:0] r;
        logic        a;
        basic[0] = 16'h0001; basic[1] = 16'hFFFF; basic[2] = 16'h7FFF; basic[3] = 16'h8000;
        reset_n = 1'b0; arm = 1'b0; length = 16'h0; sample_in = 16'h0;
        sample_valid = 1'b0; ep_read = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        chk("reset_status", {16'h0, status}, 32'h0);
        chk("reset_data", {16'h0, ep_datain}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);

        // read while idle is an underrun returning zero
        cyc(1'b0, 16'd0, 1'b0, 16'h0, 1'b1);
        chk("idle_underrun_status", {16'h0, status}, 32'h0004);

        // basic capture and readback
        cyc(1'b1, 16'd4, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'd4, 1'b1, basic[i], 1'b0);
        idle(2);
        got_q.delete();
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'd4, 1'b0, 16'h0, 1'b1);
        chk("basic_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("basic_word", {16'h0, got_q[i]}, {16'h0, basic[i]});
        chk("basic_status", {16'h0, status}, 32'h0040);
        chk("basic_done", {31'h0, done}, 32'h0);

        // gapped samples
        cyc(1'b1, 16'd3, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'd3, 1'b1, 16'h1234, 1'b0);
        cyc(1'b0, 16'd3, 1'b0, 16'hDEAD, 1'b0);
        cyc(1'b0, 16'd3, 1'b0, 16'hDEAD, 1'b0);
        cyc(1'b0, 16'd3, 1'b1, 16'hBEEF, 1'b0);
        cyc(1'b0, 16'd3, 1'b0, 16'hDEAD, 1'b0);
        chk("gap_still_capture", {30'h0, status[1:0]}, 32'd1);
        cyc(1'b0, 16'd3, 1'b1, 16'h0F0F, 1'b0);
        chk("gap_ready", {30'h0, status[1:0]}, 32'd2);
        idle(2);
        got_q.delete();
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'd3, 1'b0, 16'h0, 1'b1);
        chk("gap_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("gap_a", {16'h0, got_q[0]}, 32'h1234);
            chk("gap_b", {16'h0, got_q[1]}, 32'hBEEF);
            chk("gap_c", {16'h0, got_q[2]}, 32'h0F0F);
        end

        // length clamp (0 and 2000) with a ramp and full-rate readback
        for (int pass = 0; pass < 2; pass++) begin
            r = (pass == 0) ? 16'd0 : 16'd2000;
            cyc(1'b1, r, 1'b0, 16'h0, 1'b0);
            for (int i = 0; i < 1023; i++) cyc(1'b0, r, 1'b1, 16'(i), 1'b0);
            chk("clamp_capture_1023", {30'h0, status[1:0]}, 32'd1);
            cyc(1'b0, r, 1'b1, 16'd1023, 1'b0);
            chk("clamp_ready_1024", {30'h0, status[1:0]}, 32'd2);
            idle(2);
            got_q.delete();
            for (int i = 0; i < 1024; i++) cyc(1'b0, r, 1'b0, 16'h0, 1'b1);
            chk("clamp_count", got_q.size(), 1024);
            for (int i = 0; i < 1024 && i < got_q.size(); i++) chk("clamp_ramp", {16'h0, got_q[i]}, i);
            chk("clamp_words", {20'h0, status[15:4]}, 32'h400);
            chk("clamp_idle", {30'h0, status[1:0]}, 32'd0);
        end

        // underrun after the last word
        cyc(1'b1, 16'd2, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'd2, 1'b1, 16'hA5A5, 1'b0);
        cyc(1'b0, 16'd2, 1'b1, 16'h5A5A, 1'b0);
        idle(2);
        got_q.delete();
        cyc(1'b0, 16'd2, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 16'd2, 1'b0, 16'h0, 1'b1);
        chk("under_data_zero", {16'h0, ep_datain}, 32'h0);
        chk("under_done_low", {31'h0, done}, 32'h0);
        cyc(1'b0, 16'd2, 1'b0, 16'h0, 1'b1);
        chk("under_status", {16'h0, status}, 32'h0024);
        chk("under_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("under_w0", {16'h0, got_q[0]}, 32'hA5A5);
            chk("under_w1", {16'h0, got_q[1]}, 32'h5A5A);
        end

        // re-arm in the same cycle as a read mid-readout
        cyc(1'b1, 16'd8, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 16'd8, 1'b1, 16'($urandom), 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'd8, 1'b0, 16'h0, 1'b1);
        chk("rearm_pre_words", {20'h0, status[15:4]}, 32'd3);
        cyc(1'b1, 16'd8, 1'b0, 16'h0, 1'b1);
        chk("rearm_status", {16'h0, status}, 32'h0001);
        chk("rearm_done", {31'h0, done}, 32'h0);

        // async reset mid-capture, between clock edges
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'd8, 1'b1, 16'($urandom), 1'b0);
        #4 reset_n = 1'b0;
        #1;
        chk("areset_status", {16'h0, status}, 32'h0);
        chk("areset_data", {16'h0, ep_datain}, 32'h0);
        chk("areset_done", {31'h0, done}, 32'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        cyc(1'b1, 16'd2, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'd2, 1'b1, 16'h8001, 1'b0);
        cyc(1'b0, 16'd2, 1'b1, 16'h7FFE, 1'b0);
        idle(2);
        got_q.delete();
        cyc(1'b0, 16'd2, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 16'd2, 1'b0, 16'h0, 1'b1);
        chk("post_reset_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("post_reset_w0", {16'h0, got_q[0]}, 32'h8001);
            chk("post_reset_w1", {16'h0, got_q[1]}, 32'h7FFE);
        end

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            a = (m_state == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            r = 16'($urandom_range(1, 12));
            cyc(a, r, ($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 9) < 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
